bus_slave_mem: RTL and testbench
================================

// Module: bus_slave_mem
// PURPOSE
//  Memory-mapped word responder: the slave end of the DMAC master bus (req/ack).
//  Accepts one read or write request at a time and completes it after a fixed,
//  configurable number of wait states. Gives DMAC source/destination transfers a
//  cycle-accurate target with an error response for unmapped addresses.
// PARAMETERS
//  ADDR_W  8    word-address width
//  DEPTH   200  implemented words; addresses >= DEPTH are unmapped (DEPTH <= 2**ADDR_W)
//  WAIT    2    wait-state cycles between request capture and ack (0..15)
// PORTS
//  clk      in   1       clock, rising edge
//  reset_n  in   1       asynchronous, active-low reset
//  m_req    in   1       master request, level; held until ack is seen
//  m_wr     in   1       1 = write, 0 = read; valid with m_req
//  m_addr   in   ADDR_W  word address; valid with m_req
//  m_wdata  in   32      write data; valid with m_req
//  s_ack    out  1       one-cycle completion pulse
//  s_err    out  1       pulses with s_ack when the address was unmapped
//  s_rdata  out  32      read data; valid in the s_ack cycle, held until next read ack
//  s_busy   out  1       1 from capture cycle up to and including the ack cycle
// BEHAVIOUR
//  - Reset: state IDLE, s_ack=0, s_err=0, s_rdata=0, s_busy=0, wait counter=0.
//    Memory array is not reset; contents undefined after power-up.
//  - FSM IDLE/WAIT/ACK, all outputs registered.
//    IDLE: m_req=1 on edge -> capture wr/addr/wdata, counter<=WAIT;
//      next state WAIT if WAIT>0, else ACK. s_busy=1 from the next cycle.
//    WAIT: counter decrements each cycle; on counter==1 -> ACK.
//    ACK: s_ack=1 for exactly one cycle; write committed to memory on the edge
//      entering ACK; read data loaded into s_rdata on the same edge; -> IDLE.
//  - Latency: request sampled at edge N -> s_ack high in cycle N+WAIT+1.
//    Master drops m_req on the edge where it samples s_ack=1; ACK state ignores
//    m_req, so back-to-back transfers take WAIT+2 cycles each.
//  - m_req/m_wr/m_addr/m_wdata changes after capture are ignored until IDLE.
//  - Unmapped (m_addr >= DEPTH): write discarded, read returns 32'hDEAD_BEEF,
//    s_err=1 in the ack cycle. Mapped access: s_err=0.
//  - Write ack leaves s_rdata unchanged.
//  - Reset mid-transfer: FSM to IDLE immediately, no ack issued; a write not yet
//    in ACK is not committed.
//  - Counter 4 bits; WAIT>15 is a configuration error (elaboration check).
// STRUCTURE
//  - Shared package: state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2),
//    ERR_RDATA=32'hDEAD_BEEF, WAIT_CNT_W=4.
//  - Sub-module: bus_wait_cnt (load/decrement down-counter with terminal flag,
//    async active-low reset); FSM, capture registers and memory stay here.
//  - Capture/output regs: resettable 1/ADDR_W/32-bit flops; s_rdata is a
//    32-bit resettable flop with enable.
// TESTING
//  1 Reset: reset_n=0 mid-WAIT -> s_ack,s_err,s_busy=0, s_rdata=0; no ack after release.
//  2 Write 32'h1234_5678 @ 8'h10, WAIT=2: req at edge N -> s_ack cycle N+3, s_err=0;
//    read @8'h10 -> s_rdata=32'h1234_5678 on its ack.
//  3 WAIT=0: read captured edge N -> s_ack in cycle N+1; back-to-back reads ack
//    every 2 cycles, s_busy high in each ack cycle.
//  4 Unmapped: write 32'hFFFF_FFFF @8'hC8 (DEPTH=200) -> s_ack+s_err; read @8'hC8
//    -> s_rdata=32'hDEAD_BEEF, s_err=1; read @8'hC7 returns prior data, s_err=0.
//  5 Bus change during WAIT: m_addr 8'h10->8'h20 after capture -> access uses 8'h10.
//  6 Write ack after a read: s_rdata keeps the previous read value.

Source files
------------

// File: rtl/bus_slave_mem_pkg.sv
// Shared encodings and constants for the bus_slave_mem responder and its wait counter.
package bus_slave_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;
    localparam int          WAIT_CNT_W = 4;

endpackage

// File: rtl/bus_wait_cnt.sv
// Loadable down-counter; term is high while the count equals one.
// Latency: term is registered one edge after load; counting stops at zero.
module bus_wait_cnt
    import bus_slave_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  term
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/bus_slave_mem.sv
// Word memory slave on the DMAC req/ack bus; ack WAIT+1 cycles after capture.
// One transfer outstanding; the master holds m_req until it sees s_ack.
module bus_slave_mem
    import bus_slave_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 200,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m_req,
    input  logic              m_wr,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              s_ack,
    output logic              s_err,
    output logic [31:0]       s_rdata,
    output logic              s_busy
);

    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
        $error("bus_slave_mem: WAIT must be in 0..15");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("bus_slave_mem: DEPTH must be in 1..2**ADDR_W");
    end

    localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT);

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                s_ack_q, s_ack_d;
    logic                s_err_q, s_err_d;
    logic [31:0]         s_rdata_q, s_rdata_d;
    logic                s_busy_q, s_busy_d;

    logic                cnt_load, cnt_dec, cnt_term;
    logic                go_ack, mapped, mem_we;
    logic                eff_wr;
    logic [ADDR_W-1:0]   eff_addr;
    logic [31:0]         eff_wdata;

    logic [31:0] mem [DEPTH];

    bus_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (WAIT_LD),
        .dec      (cnt_dec),
        .term     (cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        s_ack_d   = 1'b0;
        s_err_d   = 1'b0;
        s_rdata_d = s_rdata_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        go_ack    = 1'b0;

        // With WAIT=0 the ack is entered on the capture edge, so the live bus is the access.
        eff_wr    = (state_q == ST_IDLE) ? m_wr    : wr_q;
        eff_addr  = (state_q == ST_IDLE) ? m_addr  : addr_q;
        eff_wdata = (state_q == ST_IDLE) ? m_wdata : wdata_q;
        mapped    = ({1'b0, eff_addr} < (ADDR_W + 1)'(DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    wr_d     = m_wr;
                    addr_d   = m_addr;
                    wdata_d  = m_wdata;
                    cnt_load = 1'b1;
                    if (WAIT == 0) begin
                        state_d = ST_ACK;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_term) begin
                    state_d = ST_ACK;
                    go_ack  = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (go_ack) begin
            s_ack_d = 1'b1;
            s_err_d = !mapped;
            if (!eff_wr) begin
                s_rdata_d = mapped ? mem[eff_addr] : ERR_RDATA;
            end
        end

        s_busy_d = (state_d != ST_IDLE);
        mem_we   = go_ack && eff_wr && mapped;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            s_ack_q   <= 1'b0;
            s_err_q   <= 1'b0;
            s_rdata_q <= '0;
            s_busy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            s_ack_q   <= s_ack_d;
            s_err_q   <= s_err_d;
            s_rdata_q <= s_rdata_d;
            s_busy_q  <= s_busy_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[eff_addr] <= eff_wdata;
        end
    end

    assign s_ack   = s_ack_q;
    assign s_err   = s_err_q;
    assign s_rdata = s_rdata_q;
    assign s_busy  = s_busy_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: one instance with WAIT=2 (index 0), one with WAIT=0 (index 1).
module tb_bus_slave_mem;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] er;
        bit          ee;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        bit          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       m_req = '0;
    logic             m_wr = 1'b0;
    logic [7:0]       m_addr = '0;
    logic [31:0]      m_wdata = '0;
    logic [1:0]       s_ack, s_err, s_busy;
    logic [1:0][31:0] s_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    bus_slave_mem #(.ADDR_W(8), .DEPTH(200), .WAIT(2)) u_w2 (
        .clk(clk), .reset_n(reset_n), .m_req(m_req[0]), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .s_ack(s_ack[0]), .s_err(s_err[0]),
        .s_rdata(s_rdata[0]), .s_busy(s_busy[0])
    );

    bus_slave_mem #(.ADDR_W(8), .DEPTH(200), .WAIT(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .m_req(m_req[1]), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .s_ack(s_ack[1]), .s_err(s_err[1]),
        .s_rdata(s_rdata[1]), .s_busy(s_busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation of its instance.
    initial begin
        exp_t e;
        bit   have;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (s_ack[d]) begin
                    have = 1'b0;
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        chk($sformatf("unexpected_ack%0d", d), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("s_err%0d", d), {31'd0, s_err[d]}, {31'd0, e.err});
                        chk($sformatf("s_rdata%0d", d), s_rdata[d], e.rd);
                        chk($sformatf("busy_in_ack%0d", d), {31'd0, s_busy[d]}, 32'd1);
                    end
                end
            end
        end
    end

    // Called at posedge+1; drives one request and measures cycles to ack.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] er, input bit ee,
                        input int exp_lat, input bit gap, input bit chg,
                        input logic [7:0] addr2);
        int cyc;
        bit seen;
        exp_t e;
        e.rd  = er;
        e.err = ee;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        m_wr    = wr;
        m_addr  = addr;
        m_wdata = wdata;
        m_req[d] = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (chg && cyc == 1) begin
                m_addr  = addr2;
                m_wdata = ~wdata;
                m_wr    = ~wr;
            end
            seen = s_ack[d];
        end
        m_req[d] = 1'b0;
        chk($sformatf("latency%0d_%s_%h", d, wr ? "wr" : "rd", addr),
            seen ? cyc : -1, exp_lat);
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int any_ack;

        tbl[0]  = '{1'b1, 8'h10, 32'h1234_5678, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 8'h10, 32'h0,         32'h1234_5678, 1'b0};
        tbl[2]  = '{1'b1, 8'hC8, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        tbl[3]  = '{1'b0, 8'hC8, 32'h0,         32'hDEAD_BEEF, 1'b1};
        tbl[4]  = '{1'b1, 8'hC7, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0};
        tbl[5]  = '{1'b0, 8'hC7, 32'h0,         32'hA5A5_0001, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 32'h0000_0001, 32'hA5A5_0001, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0001, 1'b0};
        tbl[8]  = '{1'b1, 8'hFF, 32'h0000_0055, 32'h0000_0001, 1'b1};
        tbl[9]  = '{1'b0, 8'hFF, 32'h0,         32'hDEAD_BEEF, 1'b1};
        tbl[10] = '{1'b0, 8'h10, 32'h0,         32'h1234_5678, 1'b0};
        tbl[11] = '{1'b1, 8'h10, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        tbl[12] = '{1'b0, 8'h10, 32'h0,         32'hCAFE_F00D, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ack%0d", d),   {31'd0, s_ack[d]},  32'd0);
            chk($sformatf("rst_err%0d", d),   {31'd0, s_err[d]},  32'd0);
            chk($sformatf("rst_busy%0d", d),  {31'd0, s_busy[d]}, 32'd0);
            chk($sformatf("rst_rdata%0d", d), s_rdata[d],         32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 13; i++) begin
                xfer(d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].er, tbl[i].ee,
                     (d == 0) ? 3 : 1, 1'b1, 1'b0, 8'h00);
            end
        end

        // WAIT=0 back-to-back: the second and later requests wait out the ack cycle.
        xfer(1, 1'b0, 8'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b0, 1'b0, 8'h00);
        xfer(1, 1'b0, 8'hC7, 32'h0, 32'hA5A5_0001, 1'b0, 2, 1'b0, 1'b0, 8'h00);
        xfer(1, 1'b0, 8'hC8, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 1'b1, 1'b0, 8'h00);
        chk("idle_busy1", {31'd0, s_busy[1]}, 32'd0);

        // Bus changes after capture must not affect the access in flight.
        xfer(0, 1'b1, 8'h20, 32'h2020_2020, 32'hCAFE_F00D, 1'b0, 3, 1'b1, 1'b0, 8'h00);
        xfer(0, 1'b0, 8'h10, 32'h0,         32'hCAFE_F00D, 1'b0, 3, 1'b1, 1'b1, 8'h20);
        xfer(0, 1'b1, 8'h10, 32'h7777_7777, 32'hCAFE_F00D, 1'b0, 3, 1'b1, 1'b1, 8'h20);
        xfer(0, 1'b0, 8'h20, 32'h0,         32'h2020_2020, 1'b0, 3, 1'b1, 1'b0, 8'h00);
        xfer(0, 1'b0, 8'h10, 32'h0,         32'h7777_7777, 1'b0, 3, 1'b1, 1'b0, 8'h00);

        // Reset during WAIT: no ack, outputs cleared, pending write dropped.
        m_wr = 1'b1; m_addr = 8'h10; m_wdata = 32'hBADB_AD00; m_req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_mid_wait", {31'd0, s_busy[0]}, 32'd1);
        reset_n = 1'b0;
        m_req[0] = 1'b0;
        #1;
        chk("midrst_ack",   {31'd0, s_ack[0]},  32'd0);
        chk("midrst_err",   {31'd0, s_err[0]},  32'd0);
        chk("midrst_busy",  {31'd0, s_busy[0]}, 32'd0);
        chk("midrst_rdata", s_rdata[0],         32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        any_ack = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (s_ack[0]) any_ack = 1;
        end
        chk("no_ack_after_rst", any_ack, 0);
        xfer(0, 1'b0, 8'h10, 32'h0, 32'h7777_7777, 1'b0, 3, 1'b1, 1'b0, 8'h00);

        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
